// File: rtl/chacha_block_core.sv
// chacha_block_core
//   Iterative ChaCha block function. A 16-word input state is loaded, ROUNDS
//   rounds are applied with QR_PER_CYCLE quarter-round datapaths per clock,
//   and the 512-bit result is presented with a valid/ready handshake.
//   A column or diagonal half-round counts as one round, so ChaCha20 uses ROUNDS=20.
//
//   Optional feature macro: CHACHA_FEEDFWD_EN
//     defined   : out_block = permuted state + saved input state (keystream block)
//     undefined : out_block = raw permuted state (HChaCha-style core)
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    in_state is valid
//   in_ready   out  1    core is idle and can accept a state
//   in_state   in   512  word i = bits [32i+31:32i]
//   out_valid  out  1    out_block is valid
//   out_ready  in   1    downstream accepts out_block
//   out_block  out  512  result, same word packing as in_state
//   busy       out  1    a block is in flight or waiting to drain
module chacha_block_core #(
    parameter int ROUNDS       = 20,
    parameter int QR_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         busy
);

    // Steps per half-round and total steps per block.
    localparam int STEPS_PER_HALF = (QR_PER_CYCLE > 0) ? (4 / QR_PER_CYCLE) : 1;
    localparam int NUM_STEPS      = ROUNDS * STEPS_PER_HALF;
    localparam int CNT_W          = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    generate
        if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
            $error("chacha_block_core: ROUNDS must be even and >= 2");
        end
        if (QR_PER_CYCLE != 1 && QR_PER_CYCLE != 2 && QR_PER_CYCLE != 4) begin : g_bad_qpc
            $error("chacha_block_core: QR_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter_round(input logic [31:0] a_in,
                                                   input logic [31:0] b_in,
                                                   input logic [31:0] c_in,
                                                   input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Word indices {a,b,c,d} of quarter round qn. Diagonal rounds rotate the
    // b/c/d rows by 1/2/3 columns, which reproduces the standard diagonal set.
    function automatic logic [15:0] qr_index(input logic diag_sel, input logic [1:0] qn);
        logic [1:0] b_col, c_col, d_col;
        b_col = diag_sel ? qn + 2'd1 : qn;
        c_col = diag_sel ? qn + 2'd2 : qn;
        d_col = diag_sel ? qn + 2'd3 : qn;
        return {2'b00, qn, 2'b01, b_col, 2'b10, c_col, 2'b11, d_col};
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] step;
    logic [31:0]      work      [16];
    logic [31:0]      next_work [16];
    logic [511:0]     final_block;
    logic             diag;
    logic [1:0]       qn;
    logic [15:0]      idx;
    logic [127:0]     qr_out;
`ifdef CHACHA_FEEDFWD_EN
    logic [31:0]      saved     [16];
`endif

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_ROUND) || (state == ST_DONE);

    // Odd half-rounds (by step / STEPS_PER_HALF) are diagonal rounds.
    assign diag = ((32'(step) / STEPS_PER_HALF) % 2) != 0;

    // One step: the next QR_PER_CYCLE quarter rounds of the current half-round.
    // Quarter rounds within a half-round touch disjoint words, so reading all
    // operands from the registered state is equivalent to applying them in order.
    always_comb begin
        next_work = work;
        qn        = 2'd0;
        idx       = 16'd0;
        qr_out    = 128'd0;
        for (int j = 0; j < QR_PER_CYCLE; j++) begin
            qn     = 2'((32'(step) % STEPS_PER_HALF) * QR_PER_CYCLE + j);
            idx    = qr_index(diag, qn);
            qr_out = quarter_round(work[idx[15:12]], work[idx[11:8]],
                                   work[idx[7:4]],   work[idx[3:0]]);
            next_work[idx[15:12]] = qr_out[127:96];
            next_work[idx[11:8]]  = qr_out[95:64];
            next_work[idx[7:4]]   = qr_out[63:32];
            next_work[idx[3:0]]   = qr_out[31:0];
        end
    end

    always_comb begin
        final_block = '0;
        for (int i = 0; i < 16; i++) begin
`ifdef CHACHA_FEEDFWD_EN
            final_block[32*i +: 32] = next_work[i] + saved[i];
`else
            final_block[32*i +: 32] = next_work[i];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step      <= '0;
            out_block <= '0;
            for (int i = 0; i < 16; i++) begin
                work[i] <= '0;
`ifdef CHACHA_FEEDFWD_EN
                saved[i] <= '0;
`endif
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            work[i] <= in_state[32*i +: 32];
`ifdef CHACHA_FEEDFWD_EN
                            saved[i] <= in_state[32*i +: 32];
`endif
                        end
                        step  <= '0;
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    for (int i = 0; i < 16; i++) begin
                        work[i] <= next_work[i];
                    end
                    // Final step: capture the result; the counter stops at N-1.
                    if (step == LAST_STEP) begin
                        out_block <= final_block;
                        state     <= ST_DONE;
                    end else begin
                        step <= step + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_core.sv
module tb_chacha_block_core;

    localparam int ND = 4;
    localparam int RND [ND] = '{20, 20, 12, 8};
    localparam int LAT [ND] = '{20, 80, 24, 16};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [511:0] in_state;
    logic [ND-1:0] rdy, vld, bsy;
    logic [511:0] blk [ND];

    int checks;
    int failures;
    logic [511:0] seen_blk0;

    always #5 clk = ~clk;

    chacha_block_core #(.ROUNDS(20), .QR_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_state(in_state),
        .out_valid(vld[0]), .out_ready(out_ready), .out_block(blk[0]), .busy(bsy[0]));
    chacha_block_core #(.ROUNDS(20), .QR_PER_CYCLE(1)) dut_q1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_state(in_state),
        .out_valid(vld[1]), .out_ready(out_ready), .out_block(blk[1]), .busy(bsy[1]));
    chacha_block_core #(.ROUNDS(12), .QR_PER_CYCLE(2)) dut_r12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_state(in_state),
        .out_valid(vld[2]), .out_ready(out_ready), .out_block(blk[2]), .busy(bsy[2]));
    chacha_block_core #(.ROUNDS(8), .QR_PER_CYCLE(2)) dut_r8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_state(in_state),
        .out_valid(vld[3]), .out_ready(out_ready), .out_block(blk[3]), .busy(bsy[3]));

    logic [31:0] rfc_in_w [16] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    logic [31:0] rfc_out_w [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: whole rounds applied directly to a word vector.
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [511:0] apply_qr(input logic [511:0] s, input int a, input int b,
                                              input int c, input int d);
        logic [31:0] wa, wb, wc, wd;
        logic [511:0] r;
        wa = s[32*a +: 32]; wb = s[32*b +: 32]; wc = s[32*c +: 32]; wd = s[32*d +: 32];
        wa = wa + wb; wd = rol(wd ^ wa, 16);
        wc = wc + wd; wb = rol(wb ^ wc, 12);
        wa = wa + wb; wd = rol(wd ^ wa, 8);
        wc = wc + wd; wb = rol(wb ^ wc, 7);
        r = s;
        r[32*a +: 32] = wa; r[32*b +: 32] = wb; r[32*c +: 32] = wc; r[32*d +: 32] = wd;
        return r;
    endfunction

    function automatic logic [511:0] chacha_ref(input logic [511:0] st, input int rounds);
        logic [511:0] x;
        x = st;
        for (int r = 0; r < rounds; r++) begin
            if (r % 2 == 0) begin
                x = apply_qr(x, 0, 4, 8, 12);
                x = apply_qr(x, 1, 5, 9, 13);
                x = apply_qr(x, 2, 6, 10, 14);
                x = apply_qr(x, 3, 7, 11, 15);
            end else begin
                x = apply_qr(x, 0, 5, 10, 15);
                x = apply_qr(x, 1, 6, 11, 12);
                x = apply_qr(x, 2, 7, 8, 13);
                x = apply_qr(x, 3, 4, 9, 14);
            end
        end
`ifdef CHACHA_FEEDFWD_EN
        for (int i = 0; i < 16; i++) x[32*i +: 32] = x[32*i +: 32] + st[32*i +: 32];
`endif
        return x;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom();
        return s;
    endfunction

    task automatic drain_all;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && rdy != 4'hF; i++) tick;
        check("drain_idle", 512'(rdy), 512'(4'hF));
        out_ready = 1'b0;
    endtask

    // One block through all four cores at once; optional 10-cycle stall in DONE.
    task automatic run_all(input logic [511:0] st, input string tag, input bit stall);
        int first [ND];
        bit all_seen;
        logic [511:0] hold;
        for (int d = 0; d < ND; d++) first[d] = -1;
        all_seen  = 1'b0;
        in_state  = st;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        in_state = rand_state();
        check({tag, "_accept_ctl"}, 512'({bsy, rdy, vld}), 512'({4'hF, 4'h0, 4'h0}));
        for (int c = 1; c <= 150 && !all_seen; c++) begin
            tick;
            all_seen = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (first[d] < 0 && vld[d]) first[d] = c;
                if (first[d] < 0) all_seen = 1'b0;
            end
        end
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_lat%0d", tag, d), 512'(first[d]), 512'(LAT[d]));
            check($sformatf("%s_blk%0d", tag, d), blk[d], chacha_ref(st, RND[d]));
        end
        seen_blk0 = blk[0];
        if (stall) begin
            hold     = blk[0];
            in_valid = 1'b1;
            for (int k = 0; k < 10; k++) begin
                in_state = rand_state();
                tick;
                check("stall_blk", blk[0], hold);
                check("stall_ctl", 512'({vld[0], rdy[0], bsy[0]}), 512'(3'b101));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick;
        check({tag, "_handshake"}, 512'({vld, rdy}), 512'({4'h0, 4'hF}));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [511:0] rfc_in, rfc_exp;
        logic [511:0] bb [3];
        logic [511:0] expq [$];
        int t_out [3];
        int got, nxt;
        bit acc;

        checks = 0;
        failures = 0;
        for (int i = 0; i < 16; i++) begin
            rfc_in[32*i +: 32] = rfc_in_w[i];
`ifdef CHACHA_FEEDFWD_EN
            rfc_exp[32*i +: 32] = rfc_out_w[i];
`else
            rfc_exp[32*i +: 32] = rfc_out_w[i] - rfc_in_w[i];
`endif
        end

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_state = '0;
        repeat (3) tick;
        check("reset_ctl", 512'({rdy, vld, bsy}), 512'({4'hF, 4'h0, 4'h0}));
        check("reset_blk0", blk[0], '0);
        check("reset_blk3", blk[3], '0);
        rst = 1'b0;
        tick;

        // RFC 8439 vector with a stall in DONE.
        run_all(rfc_in, "rfc", 1'b1);
        check("rfc_word0", 512'(seen_blk0[31:0]), 512'(rfc_exp[31:0]));
        check("rfc_full", seen_blk0, rfc_exp);

        // Reset in the middle of a block.
        in_state = rfc_in;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (7) tick;
        check("mid_busy", 512'(bsy), 512'(4'hF));
        rst = 1'b1;
        #1;
        check("mid_rst_ctl", 512'({rdy, vld, bsy}), 512'({4'hF, 4'h0, 4'h0}));
        check("mid_rst_blk", blk[0], '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick;
        run_all(rfc_in, "after_rst", 1'b0);
        check("after_rst_rfc", seen_blk0, rfc_exp);

        // Random states.
        for (int n = 0; n < 3; n++) run_all(rand_state(), $sformatf("rand%0d", n), 1'b0);

        // Back-to-back on the default core.
        for (int i = 0; i < 3; i++) begin
            bb[i] = rand_state();
            t_out[i] = 0;
        end
        got = 0;
        nxt = 0;
        out_ready = 1'b1;
        in_state = bb[0];
        in_valid = 1'b1;
        for (int c = 1; c <= 300 && got < 3; c++) begin
            acc = rdy[0] && in_valid;
            tick;
            if (acc) begin
                expq.push_back(chacha_ref(bb[nxt], 20));
                nxt++;
                if (nxt == 3) in_valid = 1'b0;
                else in_state = bb[nxt];
            end
            if (vld[0]) begin
                if (expq.size() > 0) check("b2b_blk", blk[0], expq.pop_front());
                else check("b2b_spurious", 512'(vld[0]), 512'(0));
                if (got < 3) t_out[got] = c;
                got++;
            end
        end
        check("b2b_count", 512'(got), 512'(3));
        check("b2b_gap1", 512'(t_out[1] - t_out[0]), 512'(22));
        check("b2b_gap2", 512'(t_out[2] - t_out[1]), 512'(22));
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
